rsa_decrypt_core: RTL

Receive-side counterpart of the encryption power stage. Recovers plaintext m = c^d mod n using MSB-first square-and-multiply over an interleaved shift-add modular multiplier. Uses the same in_rdy / out_rdy one-shot handshake as the encryption path, so the decrypt core drops into the same datapath slot. Single clock domain. No DSP inference; all multiplication is bit-serial.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_decrypt_core_if.sv | 26 ++
 rtl/rsa_modmul.sv | 64 ++++++
 rtl/rsa_decrypt_core.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA decrypt core and its bit-serial modular multiplier.
package rsa_pkg;

    localparam int RSA_WIDTH = 256;
    localparam int MM_LAT    = RSA_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        SQUARE,
        MULT,
        DONE,
        SKIP
    } rsa_dec_state_t;

    // Start-to-done distance of rsa_modmul for a given operand width.
    function automatic int mm_lat(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/rsa_decrypt_core_if.sv
// Request/result bundle of the decrypt core: one-shot in_rdy request, out_rdy result pulse.
interface rsa_decrypt_core_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
);

    logic             in_rdy;
    logic [WIDTH-1:0] cipher;
    logic [WIDTH-1:0] priv_exp;
    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] out;
    logic             out_rdy;
    logic             busy;

    modport master (
        output in_rdy, cipher, priv_exp, modulus,
        input  out, out_rdy, busy
    );

    modport slave (
        input  in_rdy, cipher, priv_exp, modulus,
        output out, out_rdy, busy
    );

endinterface

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier p = a*b mod n, one bit of a per cycle, MSB first.
// done pulses WIDTH+1 cycles after start; b and n must be below n-bound (b < n, or b = 1 for reduction).
module rsa_modmul #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q, b_q, n_q;
    logic [WIDTH+1:0] r_q, t0, t1, t2, n_ext;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    // 2r + b < 3n, so two conditional subtractions always bring r back below n.
    always_comb begin
        n_ext = {2'b00, n_q};
        t0    = (r_q << 1) + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
        t1    = (t0 >= n_ext) ? t0 - n_ext : t0;
        t2    = (t1 >= n_ext) ? t1 - n_ext : t1;
    end

    assign p = r_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q   <= a;
                b_q   <= b;
                n_q   <= n;
                r_q   <= '0;
                cnt_q <= CW'(WIDTH - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                r_q <= t2;
                a_q <= a_q << 1;
                if (cnt_q == '0) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rsa_decrypt_core.sv
// RSA decrypt m = c^d mod n by MSB-first square-and-multiply over one shared rsa_modmul.
// RSA_LZ_SKIP_EN: skip leading zero exponent bits one per cycle and seed acc with cr at the first set bit.
module rsa_decrypt_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    rsa_decrypt_core_if.slave bus
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    rsa_dec_state_t   state;
    logic [WIDTH-1:0] c_q, d_q, n_q, cr_q, acc_q, out_q;
    logic [KW-1:0]    k_q;
    logic             out_rdy_q, busy_q, mm_start, mm_done;
    logic [WIDTH-1:0] mm_a, mm_b, mm_p;

    assign bus.out     = out_q;
    assign bus.out_rdy = out_rdy_q;
    assign bus.busy    = busy_q;

    // Reduction runs Horner over the cipher bits with b=1, so any c is legal.
    always_comb begin
        mm_a = acc_q;
        mm_b = acc_q;
        case (state)
            REDUCE: begin
                mm_a = c_q;
                mm_b = WIDTH'(1);
            end
            MULT:    mm_b = cr_q;
            default: ;
        endcase
    end

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (n_q),
        .p     (mm_p),
        .done  (mm_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            c_q       <= '0;
            d_q       <= '0;
            n_q       <= '0;
            cr_q      <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            k_q       <= '0;
            out_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            mm_start  <= 1'b0;
        end else begin
            out_rdy_q <= 1'b0;
            mm_start  <= 1'b0;
            case (state)
                IDLE: begin
                    // busy still covers the out_rdy cycle; a new request lands one cycle later.
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (bus.in_rdy) begin
                        c_q      <= bus.cipher;
                        d_q      <= bus.priv_exp;
                        n_q      <= bus.modulus;
                        busy_q   <= 1'b1;
                        mm_start <= (bus.modulus != '0);
                        state    <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (n_q == '0) begin
                        acc_q <= '0;
                        state <= DONE;
                    end else if (mm_done) begin
                        cr_q  <= mm_p;
                        acc_q <= (n_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                        k_q   <= KW'(WIDTH - 1);
`ifdef RSA_LZ_SKIP_EN
                        state <= SKIP;
`else
                        state    <= SQUARE;
                        mm_start <= 1'b1;
`endif
                    end
                end
                SKIP: begin
                    if (d_q[k_q]) begin
                        acc_q <= cr_q;
                        if (k_q == '0) begin
                            state <= DONE;
                        end else begin
                            k_q      <= k_q - 1'b1;
                            state    <= SQUARE;
                            mm_start <= 1'b1;
                        end
                    end else if (k_q == '0) begin
                        state <= DONE;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                SQUARE: begin
                    if (mm_done) begin
                        acc_q <= mm_p;
                        if (d_q[k_q]) begin
                            state    <= MULT;
                            mm_start <= 1'b1;
                        end else if (k_q == '0) begin
                            state <= DONE;
                        end else begin
                            k_q      <= k_q - 1'b1;
                            mm_start <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    if (mm_done) begin
                        acc_q <= mm_p;
                        if (k_q == '0) begin
                            state <= DONE;
                        end else begin
                            k_q      <= k_q - 1'b1;
                            state    <= SQUARE;
                            mm_start <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    out_q     <= acc_q;
                    out_rdy_q <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
